// File: rtl/wavetable_tone_player.sv
`default_nettype none
// ============================================================================
// Module   : wavetable_tone_player
// Desc     : Reader side of a 32-entry, 6-bit sine wavetable ROM. A phase
//            accumulator steps the ROM address at a note-dependent rate, the
//            returned sample is latched once per PWM period and rendered as a
//            1-bit PWM audio stream.
// Options  : WAVETABLE_ENVELOPE_EN - when defined, adds a 4-bit decaying
//            gain applied to every latched sample; a note ends when the gain
//            reaches zero. When undefined, samples pass unscaled and a note
//            sustains until released.
// Revision : 1.0 - initial release
// ============================================================================
module wavetable_tone_player #(
    parameter int ACC_W       = 24,
    parameter int PWM_W       = 6,
    parameter int DECAY_TICKS = 512
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             note_on,
    input  logic             note_off,
    input  logic [ACC_W-1:0] phase_inc,
    output logic [4:0]       rom_addr,
    input  logic [PWM_W-1:0] rom_data,
    output logic [PWM_W-1:0] sample_out,
    output logic             sample_tick,
    output logic             audio_pwm,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PLAY    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;

    logic [PWM_W-1:0]   r_pwm_cnt;
    logic [ACC_W-1:0]   r_acc;
    logic [ACC_W-1:0]   r_inc;
    logic [4:0]         r_rom_addr;
    logic [PWM_W-1:0]   r_sample;
    logic               r_sample_tick;
    logic               r_audio_pwm;

    logic               w_tick;
    logic [ACC_W:0]     w_sum;
    logic               w_carry;
    logic               w_accept;
    logic               w_load_inc;
    logic               w_clear_acc;
    logic               w_to_idle;
    logic               w_env_done;
    logic [PWM_W-1:0]   w_scaled;

    // A zero decay period has no meaning; the envelope needs at least one
    // sample tick per gain step.
    if (DECAY_TICKS < 1) begin : g_decay_ticks_invalid
    end

    // One sample per PWM period, only while a note is sounding.
    assign w_tick   = (r_pwm_cnt == {PWM_W{1'b1}}) && (r_state != ST_IDLE);

    // Carry out of the top accumulator bit marks the address wrapping to 0.
    assign w_sum    = {1'b0, r_acc} + {1'b0, r_inc};
    assign w_carry  = w_sum[ACC_W];

    // A zero increment would never advance, so such note_on pulses are ignored.
    assign w_accept = note_on && (phase_inc != '0);

`ifdef WAVETABLE_ENVELOPE_EN
    localparam int DCNT_W = $clog2(DECAY_TICKS + 1);

    logic [3:0]        r_gain;
    logic [DCNT_W-1:0] r_dcnt;
    logic              w_step_gain;

    assign w_step_gain = w_tick && (r_dcnt == DCNT_W'(DECAY_TICKS - 1));
    // The last gain step from 1 to 0 silences the note.
    assign w_env_done  = w_step_gain && (r_gain == 4'd1);
    // 10-bit product, keep the upper PWM_W bits (divide by 16).
    assign w_scaled    = PWM_W'(({4'd0, rom_data} * {{PWM_W{1'b0}}, r_gain}) >> 4);

    // Gain envelope: full scale on every accepted note, decays per tick block.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_gain <= 4'd0;
            r_dcnt <= '0;
        end else if (w_load_inc) begin
            r_gain <= 4'd15;
            r_dcnt <= '0;
        end else if (w_tick) begin
            if (w_step_gain) begin
                r_dcnt <= '0;
                r_gain <= r_gain - 4'd1;
            end else begin
                r_dcnt <= r_dcnt + 1'b1;
            end
        end
    end
`else
    assign w_env_done = 1'b0;
    assign w_scaled   = rom_data;
`endif

    // Note-control state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and datapath control strobes; note_on always beats note_off.
    always_comb begin
        w_next_state = r_state;
        w_load_inc   = 1'b0;
        w_clear_acc  = 1'b0;
        w_to_idle    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = ST_PLAY;
                    w_load_inc   = 1'b1;
                    w_clear_acc  = 1'b1;
                end
            end
            ST_PLAY: begin
                if (note_on) begin
                    w_load_inc = w_accept;
                end else if (note_off) begin
                    w_next_state = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (w_accept) begin
                    w_next_state = ST_PLAY;
                    w_load_inc   = 1'b1;
                end else if (w_tick && w_carry) begin
                    w_next_state = ST_IDLE;
                    w_to_idle    = 1'b1;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
                w_to_idle    = 1'b1;
            end
        endcase
        if (w_env_done && !w_accept) begin
            w_next_state = ST_IDLE;
            w_to_idle    = 1'b1;
        end
    end

    // Phase accumulator, sample latch, ROM address and PWM rendering.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pwm_cnt     <= '0;
            r_acc         <= '0;
            r_inc         <= '0;
            r_rom_addr    <= '0;
            r_sample      <= '0;
            r_sample_tick <= 1'b0;
            r_audio_pwm   <= 1'b0;
        end else begin
            r_pwm_cnt     <= r_pwm_cnt + 1'b1;
            r_sample_tick <= w_tick;
            r_rom_addr    <= r_acc[ACC_W-1 -: 5];
            r_audio_pwm   <= (r_state != ST_IDLE) && (r_pwm_cnt < r_sample);

            if (w_load_inc) begin
                r_inc <= phase_inc;
            end

            if (w_to_idle || w_clear_acc) begin
                r_acc <= '0;
            end else if (w_tick) begin
                r_acc <= w_sum[ACC_W-1:0];
            end

            if (w_to_idle) begin
                r_sample <= '0;
            end else if (w_tick) begin
                r_sample <= w_scaled;
            end
        end
    end

    assign rom_addr    = r_rom_addr;
    assign sample_out  = r_sample;
    assign sample_tick = r_sample_tick;
    assign audio_pwm   = r_audio_pwm;
    assign busy        = (r_state != ST_IDLE);

endmodule
`default_nettype wire
